// File: rtl/negedge_tap_shifter.sv
// Addressable falling-edge shift register (SRL-style delay line) with a
// fill counter that tracks how many stages hold data written since CLEAR.
module negedge_tap_shifter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter logic [WIDTH-1:0] INIT = '0,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             CLEAR,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_LAST,
  output logic [FW-1:0]    FILL,
  output logic             Q_VALID
);

  // Power-up contents come from INIT; CLEAR always returns stages to zero.
  logic [WIDTH-1:0] stage [DEPTH] = '{default: INIT};
  logic [FW-1:0]    fill_cnt = '0;

  // Handshake: none. CE is a plain qualifier sampled at each falling CLK edge;
  // an unknown CE falls into the hold branch, so FILL never goes to X.
  always_ff @(negedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      fill_cnt <= '0;
    end else if (CE) begin
      stage[0] <= D;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      if (32'(fill_cnt) < DEPTH) fill_cnt <= fill_cnt + FW'(1);
    end
  end

  // Addresses past the last stage read as zero rather than X.
  always_comb begin
    Q = '0;
    if (32'(A) < DEPTH) Q = stage[A];
  end

  assign Q_LAST  = stage[DEPTH-1];
  assign FILL    = fill_cnt;
  assign Q_VALID = 32'(A) < 32'(fill_cnt);

endmodule

// File: tb/tb_negedge_tap_shifter.sv
// Bench for negedge_tap_shifter: a 16x8 instance with INIT=A5 and a 12x4
// instance for the out-of-range tap addresses, both against queue models.
module tb_negedge_tap_shifter;

  logic       CLK = 1'b1;
  logic       clear16 = 1'b0, ce16 = 1'b0;
  logic [7:0] d16 = '0, q16, q_last16;
  logic [3:0] a16 = '0;
  logic [4:0] fill16;
  logic       q_valid16;

  logic       clear12 = 1'b0, ce12 = 1'b0;
  logic [3:0] d12 = '0, q12, q_last12, a12 = '0, fill12;
  logic       q_valid12;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: newest word at index 0, count of words since the last clear
  logic [7:0] m_s[$];
  int         m_fill;
  logic [3:0] m12_s[$];
  int         m12_fill;

  always #5 CLK = ~CLK;

  negedge_tap_shifter #(.WIDTH(8), .DEPTH(16), .INIT(8'hA5)) dut16 (
    .CLK(CLK), .CLEAR(clear16), .CE(ce16), .D(d16), .A(a16),
    .Q(q16), .Q_LAST(q_last16), .FILL(fill16), .Q_VALID(q_valid16)
  );

  negedge_tap_shifter #(.WIDTH(4), .DEPTH(12), .INIT(4'h0)) dut12 (
    .CLK(CLK), .CLEAR(clear12), .CE(ce12), .D(d12), .A(a12),
    .Q(q12), .Q_LAST(q_last12), .FILL(fill12), .Q_VALID(q_valid12)
  );

  initial begin
    #100us;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic logic [7:0] exp_q(input int a);
    return (a < 16) ? m_s[a] : 8'h00;
  endfunction

  task automatic model_shift(input logic [7:0] d);
    m_s.push_front(d);
    void'(m_s.pop_back());
    if (m_fill < 16) m_fill++;
  endtask

  task automatic model_clear();
    m_s.delete();
    for (int i = 0; i < 16; i++) m_s.push_back(8'h00);
    m_fill = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic shift_one(input logic [7:0] d);
    @(posedge CLK); #1;
    ce16 = 1'b1; d16 = d;
    @(negedge CLK); #1;
    ce16 = 1'b0;
    model_shift(d);
  endtask

  task automatic pulse_clear();
    @(posedge CLK); #1;
    clear16 = 1'b1; #1;
    clear16 = 1'b0;
    model_clear();
  endtask

  task automatic shift12(input logic [3:0] d);
    @(posedge CLK); #1;
    ce12 = 1'b1; d12 = d;
    @(negedge CLK); #1;
    ce12 = 1'b0;
    m12_s.push_front(d);
    if (m12_s.size() > 12) void'(m12_s.pop_back());
    if (m12_fill < 12) m12_fill++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    for (int a = 0; a < 16; a++) begin
      a16 = 4'(a); #0.1;
      tests_run++;
      if (q16 !== 8'hA5 || q_valid16 !== 1'b0) begin
        tests_failed++;
        $display("FAIL powerup_q a=%0d: got q=%h v=%b, expected q=a5 v=0", a, q16, q_valid16);
      end
    end
    tests_run++;
    if (fill16 !== 5'd0 || q_last16 !== 8'hA5) begin
      tests_failed++;
      $display("FAIL powerup_fill: got fill=%0d last=%h, expected fill=0 last=a5", fill16, q_last16);
    end
    a16 = 4'd0;
    clear16 = 1'b1; #1;
    tests_run++;
    if (q16 !== 8'h00 || q_last16 !== 8'h00 || fill16 !== 5'd0) begin
      tests_failed++;
      $display("FAIL clear_async: got q=%h last=%h fill=%0d, expected 0 0 0", q16, q_last16, fill16);
    end
    clear16 = 1'b0;
    model_clear();
  endtask

  task automatic test_fill_tap();
    pulse_clear();
    for (int i = 1; i <= 20; i++) begin
      shift_one(8'(i));
      tests_run++;
      if (fill16 !== 5'(m_fill) || int'(fill16) != ((i < 16) ? i : 16)) begin
        tests_failed++;
        $display("FAIL fill_count step=%0d: got %0d, expected %0d", i, fill16, m_fill);
      end
    end
    a16 = 4'd0; #1;
    tests_run++;
    if (q16 !== 8'd20) begin
      tests_failed++;
      $display("FAIL tap0: got %0d, expected 20", q16);
    end
    a16 = 4'd5; #1;
    tests_run++;
    if (q16 !== 8'd15) begin
      tests_failed++;
      $display("FAIL tap5: got %0d, expected 15", q16);
    end
    tests_run++;
    if (q_last16 !== 8'd5) begin
      tests_failed++;
      $display("FAIL q_last: got %0d, expected 5", q_last16);
    end
    for (int a = 0; a < 16; a++) begin
      a16 = 4'(a); #0.1;
      tests_run++;
      if (q_valid16 !== 1'b1 || q16 !== exp_q(a)) begin
        tests_failed++;
        $display("FAIL full_tap a=%0d: got q=%h v=%b, expected q=%h v=1", a, q16, q_valid16, exp_q(a));
      end
    end
  endtask

  task automatic test_clock_enable();
    pulse_clear();
    shift_one(8'h11);
    shift_one(8'h22);
    shift_one(8'h33);
    repeat (10) begin
      @(posedge CLK); #1;
      d16 = 8'($urandom);
      @(negedge CLK); #1;
    end
    a16 = 4'd0; #1;
    tests_run++;
    if (q16 !== 8'h33 || fill16 !== 5'd3) begin
      tests_failed++;
      $display("FAIL ce_hold: got q=%h fill=%0d, expected q=33 fill=3", q16, fill16);
    end
    a16 = 4'd3; #1;
    tests_run++;
    if (q_valid16 !== 1'b0) begin
      tests_failed++;
      $display("FAIL ce_valid3: got %b, expected 0", q_valid16);
    end
    a16 = 4'd2; #1;
    tests_run++;
    if (q16 !== 8'h11 || q_valid16 !== 1'b1) begin
      tests_failed++;
      $display("FAIL ce_tap2: got q=%h v=%b, expected q=11 v=1", q16, q_valid16);
    end
  endtask

  task automatic test_async_clear();
    logic [7:0] d;
    pulse_clear();
    repeat (7) shift_one(8'($urandom_range(1, 255)));
    tests_run++;
    if (fill16 !== 5'd7) begin
      tests_failed++;
      $display("FAIL pre_clear_fill: got %0d, expected 7", fill16);
    end
    @(posedge CLK); #1;
    a16 = 4'd0;
    clear16 = 1'b1; #1;
    tests_run++;
    if (q16 !== 8'h00 || q_last16 !== 8'h00 || fill16 !== 5'd0 || q_valid16 !== 1'b0) begin
      tests_failed++;
      $display("FAIL midop_clear: got q=%h last=%h fill=%0d v=%b, expected all 0", q16, q_last16, fill16, q_valid16);
    end
    clear16 = 1'b0;
    model_clear();
    repeat (3) shift_one(8'($urandom_range(1, 255)));
    @(posedge CLK); #1;
    ce16 = 1'b1; d16 = 8'hFF;
    @(negedge CLK);
    clear16 = 1'b1;
    #1;
    ce16 = 1'b0;
    model_clear();
    tests_run++;
    if (q16 !== 8'h00 || fill16 !== 5'd0) begin
      tests_failed++;
      $display("FAIL coincident_clear: got q=%h fill=%0d, expected q=0 fill=0", q16, fill16);
    end
    @(posedge CLK); #1;
    clear16 = 1'b0;
    d = 8'($urandom_range(1, 255));
    shift_one(d);
    tests_run++;
    if (q16 !== d || fill16 !== 5'd1) begin
      tests_failed++;
      $display("FAIL first_after_clear: got q=%h fill=%0d, expected q=%h fill=1", q16, fill16, d);
    end
  endtask

  task automatic test_edge_polarity();
    logic [7:0] q_before;
    logic [4:0] f_before;
    a16 = 4'd0;
    @(negedge CLK); #1;
    q_before = q16; f_before = fill16;
    d16 = ~q_before; ce16 = 1'b1;
    @(posedge CLK); #1;
    ce16 = 1'b0;
    @(negedge CLK); #1;
    tests_run++;
    if (q16 !== exp_q(0) || fill16 !== 5'(m_fill) || q16 !== q_before || fill16 !== f_before) begin
      tests_failed++;
      $display("FAIL rising_edge_shift: got q=%h fill=%0d, expected q=%h fill=%0d", q16, fill16, exp_q(0), m_fill);
    end
  endtask

  task automatic test_random();
    logic ce;
    logic [7:0] d;
    for (int n = 0; n < 300; n++) begin
      @(posedge CLK); #1;
      if ($urandom_range(0, 39) == 0) begin
        clear16 = 1'b1; #1;
        clear16 = 1'b0;
        model_clear();
      end
      ce = 1'($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      ce16 = ce; d16 = d;
      a16 = 4'($urandom_range(0, 15));
      @(negedge CLK); #1;
      if (ce) model_shift(d);
      tests_run++;
      if (q16 !== exp_q(a16) || q_valid16 !== (int'(a16) < m_fill) ||
          fill16 !== 5'(m_fill) || q_last16 !== m_s[15]) begin
        tests_failed++;
        $display("FAIL random n=%0d a=%0d: got q=%h v=%b fill=%0d last=%h, expected q=%h v=%b fill=%0d last=%h",
                 n, a16, q16, q_valid16, fill16, q_last16, exp_q(a16), int'(a16) < m_fill, m_fill, m_s[15]);
      end
    end
    ce16 = 1'b0;
  endtask

  task automatic test_out_of_range();
    @(posedge CLK); #1;
    clear12 = 1'b1; #1;
    clear12 = 1'b0;
    m12_s.delete();
    m12_fill = 0;
    for (int i = 0; i < 12; i++) shift12(4'($urandom));
    tests_run++;
    if (fill12 !== 4'd12) begin
      tests_failed++;
      $display("FAIL fill12: got %0d, expected 12", fill12);
    end
    for (int a = 12; a < 16; a++) begin
      a12 = 4'(a); #0.1;
      tests_run++;
      if (q12 !== 4'h0 || q_valid12 !== 1'b0) begin
        tests_failed++;
        $display("FAIL oob a=%0d: got q=%h v=%b, expected q=0 v=0", a, q12, q_valid12);
      end
    end
    a12 = 4'd11; #1;
    tests_run++;
    if (q12 !== m12_s[11] || q_valid12 !== 1'b1 || q_last12 !== m12_s[11]) begin
      tests_failed++;
      $display("FAIL tap11: got q=%h v=%b last=%h, expected q=%h v=1", q12, q_valid12, q_last12, m12_s[11]);
    end
  endtask

  initial begin
    model_clear();
    for (int i = 0; i < 16; i++) m_s[i] = 8'hA5;
    test_reset();
    test_fill_tap();
    test_clock_enable();
    test_async_clear();
    test_edge_polarity();
    test_random();
    test_edge_polarity();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/negedge_tap_shifter.md
Name: negedge_tap_shifter

Overview:
- Addressable shift register with a fill tracker, built to sit directly downstream of the falling-edge, clock-enabled, async-clear flop models.
- Chains WIDTH-bit words through DEPTH stages on falling CLK edges when CE is high.
- Exposes a dynamically selected tap, the last stage, and a count of stages holding data written since the last clear.
- Used for Verilator models of SRL-style delay lines on Gowin fabric.

Parameters:
- WIDTH, 8, data word width in bits (1..64).
- DEPTH, 16, number of shift stages (2..64).
- INIT, 0, power-up value of every stage in simulation (WIDTH bits); does not apply after CLEAR.

Ports:
- CLK  in  1  clock; all state updates on the falling edge.
- CLEAR  in  1  asynchronous, active-high reset.
- CE  in  1  clock enable; shift occurs only when high at a falling CLK edge.
- D  in  WIDTH  word shifted into stage 0.
- A  in  AW = max(1, clog2(DEPTH))  tap address; 0 selects stage 0.
- Q  out  WIDTH  contents of stage A (combinational from the stage array and A).
- Q_LAST  out  WIDTH  contents of stage DEPTH-1.
- FILL  out  FW = clog2(DEPTH+1)  number of valid stages; saturates at DEPTH.
- Q_VALID  out  1  high when A < FILL (stage A holds data written since the last clear).

Behaviour:
- Single clock domain. Sequential state is the stage array S[0..DEPTH-1] and the counter FILL. Q, Q_LAST and Q_VALID are combinational.
- Power-up (simulation initial): every S[i] = INIT; FILL = 0.
- CLEAR high: immediately, without waiting for a clock edge, every S[i] = 0 and FILL = 0. Q = 0, Q_LAST = 0, Q_VALID = 0. State holds there while CLEAR stays high, regardless of CLK and CE.
- Falling CLK edge with CLEAR low and CE high:
  - S[0] <= D.
  - S[i] <= S[i-1] for 1 <= i < DEPTH.
  - FILL <= FILL+1 if FILL < DEPTH, else FILL holds at DEPTH.
- Falling CLK edge with CE low: all state holds.
- Rising CLK edges: no effect.
- Latency: a word presented on D with CE high appears at S[k] after k+1 enabled falling edges.
  - With A = k, it appears at Q after the (k+1)th enabled edge.
  - It appears at Q_LAST after DEPTH enabled edges.
- Address out of range (A >= DEPTH, possible when DEPTH is not a power of 2): Q = 0 and Q_VALID = 0. No X propagation.
- A may change at any time. Q and Q_VALID follow A combinationally with no clock involvement.
- Simultaneous CLEAR assertion and a falling edge: CLEAR wins; the result is all-zero with FILL = 0.
- CLEAR deasserted: the first falling edge with CE high loads S[0] and sets FILL = 1.
- CLEAR mid-fill: all partial contents are discarded and FILL restarts from 0.
- FILL saturation: once FILL = DEPTH it stays at DEPTH on further shifts. It does not wrap.
- X on CE with CLEAR low at a falling edge: the model must not corrupt FILL into X. Treat CE as low (hold).
- No combinational path from D to any output.

Test Plan:
- Power-up and clear (WIDTH=8, DEPTH=16, INIT=8'hA5): with CLEAR low and no edges, Q = 8'hA5 for every A < 16 and FILL = 0. Pulse CLEAR without clocking -> Q = 0, Q_LAST = 0, FILL = 0 immediately.
- Fill and tap: after CLEAR, shift D = 1,2,...,20 with CE high on 20 falling edges.
  - FILL reads 1..16, then holds at 16.
  - Final state: A=0 -> Q = 20; A=5 -> Q = 15; Q_LAST = 5; Q_VALID = 1 for all A.
- Clock enable: shift 3 words (0x11, 0x22, 0x33), then toggle CLK 10 falling edges with CE low -> Q at A=0 stays 0x33 and FILL stays 3. A=3 -> Q_VALID = 0. A=2 -> Q = 0x11 and Q_VALID = 1.
- Async clear mid-operation: with FILL = 7, assert CLEAR between edges -> outputs and FILL go to 0 before the next edge. Assert CLEAR coincident with a falling edge while CE=1, D=0xFF -> S[0] = 0 and FILL = 0.
- Out-of-range address (DEPTH=12, WIDTH=4): fill 12 words, set A = 13 -> Q = 0 and Q_VALID = 0. Set A = 11 -> Q equals the first word shifted in and Q_VALID = 1.
- Edge polarity: change D and pulse CE high only across a rising edge, dropping CE before the falling edge -> no shift and FILL unchanged.
